// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-aware arbiter merging valid/ready producers into one FIFO write port.
// Optional per-requester packet counters are enabled by defining FIFO_ARB_PKT_COUNT_EN.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH     = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQUESTERS-1:0]            i_req_valid,
  input  logic [NUM_REQUESTERS-1:0]            i_req_last,
  output logic [NUM_REQUESTERS-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]                o_data,
  output logic                                 o_last,
  output logic [((NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1)-1:0] o_source,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [NUM_REQUESTERS*16-1:0]         o_pkt_count
);

  localparam int unsigned SourceWidth = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam logic [SourceWidth-1:0] LastIdx = SourceWidth'(NUM_REQUESTERS - 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                   state_q;
  logic [SourceWidth-1:0]   ptr_q;
  logic [SourceWidth-1:0]   owner_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     last_q;
  logic [SourceWidth-1:0]   source_q;
  logic                     valid_q;

  logic                      accept;
  logic                      found;
  logic                      xfer;
  logic                      winner_last;
  logic [SourceWidth-1:0]    winner;
  logic [SourceWidth-1:0]    next_ptr;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [DATA_WIDTH-1:0]     winner_data;

  assign accept = !valid_q || i_ready;

  // While locked the owner keeps the grant even when it is not valid.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    if (state_q == StLocked) begin
      winner = owner_q;
      found  = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
        if (!found && i_req_valid[idx]) begin
          found  = 1'b1;
          winner = SourceWidth'(idx);
        end
      end
    end
    if (found) grant[winner] = 1'b1;
  end

  assign winner_last = i_req_last[winner];
  assign winner_data = i_req_data[32'(winner) * DATA_WIDTH +: DATA_WIDTH];
  assign xfer        = accept && found && i_req_valid[winner];
  assign next_ptr    = (winner == LastIdx) ? '0 : winner + 1'b1;

  // Gated by reset so no producer sees a handshake while the block is held in reset.
  assign o_req_ready = (accept && i_rst_n) ? grant : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
    end else if (xfer) begin
      unique case (state_q)
        StIdle: begin
          if (winner_last) begin
            ptr_q <= next_ptr;
          end else begin
            state_q <= StLocked;
            owner_q <= winner;
          end
        end
        StLocked: begin
          if (winner_last) begin
            state_q <= StIdle;
            ptr_q   <= next_ptr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q   <= '0;
      last_q   <= 1'b0;
      source_q <= '0;
      valid_q  <= 1'b0;
    end else if (xfer) begin
      data_q   <= winner_data;
      last_q   <= winner_last;
      source_q <= winner;
      valid_q  <= 1'b1;
    end else if (i_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign o_data   = data_q;
  assign o_last   = last_q;
  assign o_source = source_q;
  assign o_valid  = valid_q;

`ifdef FIFO_ARB_PKT_COUNT_EN
  logic [15:0] pkt_cnt_q [NUM_REQUESTERS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < NUM_REQUESTERS; k++) pkt_cnt_q[k] <= '0;
    end else if (xfer && winner_last) begin
      for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
        if (winner == SourceWidth'(k) && pkt_cnt_q[k] != 16'hFFFF) begin
          pkt_cnt_q[k] <= pkt_cnt_q[k] + 16'd1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REQUESTERS; k++) begin : g_cnt_out
    assign o_pkt_count[k*16 +: 16] = pkt_cnt_q[k];
  end
`else
  assign o_pkt_count = '0;
`endif

endmodule
